// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//
// UART transmit engine. It contains the control FSM, the shift-register
// serializer, the parity generator and the registered line driver. A frame
// is captured from the parallel side, its configuration is frozen in shadow
// registers, and the frame is then shifted out LSB first, one bit per baud
// tick.
//
// Ports
//   CLK         in   TX clock
//   RST         in   synchronous reset, active-high
//   P_DATA      in   parallel payload (DATA_WIDTH bits)
//   Data_Valid  in   request to send P_DATA (taken when idle or on final stop tick)
//   PAR_EN      in   append a parity bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   STOP2       in   0 = one stop bit, 1 = two stop bits
//   tick        in   baud enable; bit boundaries occur only on tick cycles
//   TX_OUT      out  serial line, registered, idles high
//   busy        out  frame in progress, registered
//   done        out  one-cycle pulse on the final stop-bit tick
// ---------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  tick,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    stop2_q, stop2_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    final_tick;
  logic                    capture;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    final_tick = 1'b0;
    capture    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Capture does not wait for a tick, so the start bit may be short.
        capture = Data_Valid;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            final_tick = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (tick) begin
          final_tick = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The final stop tick doubles as a capture slot so that back-to-back
    // frames leave no idle cycle between stop and start bits.
    if (final_tick) begin
      state_d = S_IDLE;
      capture = Data_Valid;
    end

    if (capture) begin
      state_d  = S_START;
      shreg_d  = P_DATA;
      par_en_d = PAR_EN;
      stop2_d  = STOP2;
      par_d    = (^P_DATA) ^ PAR_TYP;
    end

    // The line register always shows the bit belonging to the next state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;
  // Suppressed while reset is asserted so an aborted frame never reports done.
  assign done   = final_tick & ~RST;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
//
// Two engines (8-bit and 5-bit payload) share all control inputs. A predictor
// turns every accepted request into the list of line bits the frame must
// produce; a monitor walks that list, one entry per tick, and compares line,
// busy and done every cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int DEPTH = 4096;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] pdata;
  logic       dv;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic       tick = 1'b0;
  int         tick_mode = 0;
  int         tcnt = 0;

  logic tx8, busy8, done8;
  logic tx5, busy5, done5;

  int n_assert = 0;
  int n_fail   = 0;

  bit   expb [2][DEPTH];
  int   wr [2] = '{0, 0};
  int   rd [2] = '{0, 0};
  int   fl [2] = '{0, 0};
  bit   armed = 1'b0;

  uart_tx_engine #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(pdata), .Data_Valid(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .tick(tick),
    .TX_OUT(tx8), .busy(busy8), .done(done8)
  );

  uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(pdata[4:0]), .Data_Valid(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .tick(tick),
    .TX_OUT(tx5), .busy(busy5), .done(done5)
  );

  always #5 CLK = ~CLK;

  // Baud enable: always, every Nth cycle, or random.
  always @(posedge CLK) begin
    #1;
    tcnt = tcnt + 1;
    if (tick_mode == 0)      tick = 1'b1;
    else if (tick_mode < 0)  tick = 1'($urandom_range(0, 1));
    else                     tick = ((tcnt % tick_mode) == 0);
  end

  function automatic int wid(input int g);
    return (g == 0) ? 8 : 5;
  endfunction

  // Predictor: a request is taken when the engine has no bits left to send
  // (idle, or its last stop bit just completed on a tick).
  always @(posedge CLK) begin
    for (int g = 0; g < 2; g++) begin
      if (RST) begin
        fl[g] = wr[g];
      end else if (armed && (wr[g] == rd[g]) && dv) begin
        int ones;
        ones = 0;
        expb[g][wr[g] % DEPTH] = 1'b0;
        wr[g] = wr[g] + 1;
        for (int i = 0; i < wid(g); i++) begin
          expb[g][wr[g] % DEPTH] = pdata[i];
          ones = ones + int'(pdata[i]);
          wr[g] = wr[g] + 1;
        end
        if (par_en) begin
          expb[g][wr[g] % DEPTH] = 1'((ones % 2) == 1) ^ par_typ;
          wr[g] = wr[g] + 1;
        end
        expb[g][wr[g] % DEPTH] = 1'b1;
        wr[g] = wr[g] + 1;
        if (stop2) begin
          expb[g][wr[g] % DEPTH] = 1'b1;
          wr[g] = wr[g] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int g, input logic act, input logic exp);
    n_assert = n_assert + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s w%0d @%0t: got %b expected %b", name, wid(g), $time, act, exp);
    end
  endtask

  // Monitor: the front entry is the bit on the line now; it is retired on a
  // tick cycle, and the last entry of a frame must coincide with done.
  always @(negedge CLK) begin
    if (armed) begin
      for (int g = 0; g < 2; g++) begin
        int   n;
        logic e_tx, a_tx, a_busy, a_done;
        if (rd[g] < fl[g]) rd[g] = fl[g];
        n      = wr[g] - rd[g];
        e_tx   = (n > 0) ? expb[g][rd[g] % DEPTH] : 1'b1;
        a_tx   = (g == 0) ? tx8   : tx5;
        a_busy = (g == 0) ? busy8 : busy5;
        a_done = (g == 0) ? done8 : done5;
        check("tx_out", g, a_tx, e_tx);
        check("busy",   g, a_busy, 1'(n > 0));
        check("done",   g, a_done, 1'(!RST && tick && (n == 1)));
        if (!RST && tick && (n > 0)) rd[g] = rd[g] + 1;
      end
    end
    if (RST) armed = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    pdata   = d;
    par_en  = pe;
    par_typ = pt;
    stop2   = s2;
    dv      = 1'b1;
    step(1);
    dv      = 1'b0;
  endtask

  initial begin
    RST = 1'b1; dv = 1'b0; pdata = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    tick_mode = 0;
    step(2);
    RST = 1'b0;
    step(20);

    // 8N1 and parity / stop-bit variants
    send(8'hA5, 1'b0, 1'b0, 1'b0); step(14);
    send(8'h03, 1'b1, 1'b0, 1'b0); step(14);
    send(8'h03, 1'b1, 1'b1, 1'b0); step(14);
    send(8'h03, 1'b1, 1'b0, 1'b1); step(16);

    // tick every 4th cycle, config disturbed mid-frame
    tick_mode = 4;
    send(8'h81, 1'b0, 1'b0, 1'b0); step(10);
    par_en = 1'b1; pdata = 8'hFF; par_typ = 1'b1; stop2 = 1'b1; step(20);
    pdata = 8'h3C; par_en = 1'b0; step(30);
    tick_mode = 0;
    par_typ = 1'b0; stop2 = 1'b0; step(4);

    // back-to-back with Data_Valid held high
    pdata = 8'h55; par_en = 1'b0; dv = 1'b1; step(1);
    pdata = 8'hAA; step(11);
    dv = 1'b0; step(20);

    // reset during the data bits
    send(8'hC3, 1'b0, 1'b0, 1'b0); step(4);
    RST = 1'b1; step(1);
    RST = 1'b0; step(6);

    // 5-bit frame with even parity
    send(8'h15, 1'b1, 1'b0, 1'b0); step(16);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      tick_mode = (r == 0) ? 0 : (r == 1) ? -1 : r + 1;
      for (int j = 0; j < 25; j++) begin
        dv      = ($urandom_range(0, 3) == 0);
        pdata   = 8'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        stop2   = 1'($urandom);
        RST     = ($urandom_range(0, 150) == 0);
        step(1);
      end
    end
    RST = 1'b0; dv = 1'b0; tick_mode = 0;
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
